// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the camera/SA stream mux and demux pair.
package stream_demux_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  // Route bit sampled with each word: camera (byte path) or systolic array.
  localparam logic ROUTE_CAMERA = 1'b0;
  localparam logic ROUTE_SA     = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SA_OUT = 2'd1,
    CAM_HI = 2'd2,
    CAM_LO = 2'd3
  } demux_state_t;

endpackage

// File: rtl/stream_demux_if.sv
// Bundle of the input word stream plus both output paths of stream_demux.
interface stream_demux_if
  import stream_demux_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int BW = BYTE_W
);

  logic          en;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tlast;

  logic          tvalid_camera;
  logic          tready_camera;
  logic [BW-1:0] tdata_camera;
  logic          tlast_camera;

  logic          tvalid_SA;
  logic          tready_SA;
  logic [DW-1:0] tdata_SA;
  logic          tlast_SA;

  // slave: the demux itself; master: whoever feeds it and sinks its outputs.
  modport slave (
    input  en, s_tvalid, s_tdata, s_tlast, tready_camera, tready_SA,
    output s_tready, tvalid_camera, tdata_camera, tlast_camera,
    output tvalid_SA, tdata_SA, tlast_SA
  );

  modport master (
    output en, s_tvalid, s_tdata, s_tlast, tready_camera, tready_SA,
    input  s_tready, tvalid_camera, tdata_camera, tlast_camera,
    input  tvalid_SA, tdata_SA, tlast_SA
  );

endinterface

// File: rtl/stream_demux.sv
// Routes each 16-bit input word to the SA word path or, split high byte first,
// to the camera byte path, with one word held between input and output.
//
//   state  | meaning
//   IDLE   | nothing held, ready for a word
//   SA_OUT | held word presented on the SA path
//   CAM_HI | high byte of held word presented on the camera path
//   CAM_LO | low byte (and tlast) presented on the camera path
module stream_demux
  import stream_demux_pkg::*;
(
  input  logic          aclk,
  input  logic          aresetn,
  stream_demux_if.slave bus
);

  demux_state_t      r_state;
  demux_state_t      w_next;
  logic              r_live;
  logic [DATA_W-1:0] r_sa_data;
  logic              r_sa_last;
  logic [BYTE_W-1:0] r_cam_data;
  logic              r_cam_last;
  logic [BYTE_W-1:0] r_lo_byte;
  logic              r_lo_last;

  logic w_s_tready;
  logic w_accept;
  logic w_sa_done;
  logic w_cam_hi_done;
  logic w_cam_lo_done;

  // Input readiness follows the sink that frees the holding register this cycle.
  always_comb begin
    w_s_tready = 1'b0;
    case (r_state)
      IDLE:    w_s_tready = r_live;
      SA_OUT:  w_s_tready = bus.tready_SA;
      CAM_HI:  w_s_tready = 1'b0;
      CAM_LO:  w_s_tready = bus.tready_camera;
      default: w_s_tready = 1'b0;
    endcase
  end

  assign w_accept      = bus.s_tvalid & w_s_tready;
  assign w_sa_done     = (r_state == SA_OUT) & bus.tready_SA;
  assign w_cam_hi_done = (r_state == CAM_HI) & bus.tready_camera;
  assign w_cam_lo_done = (r_state == CAM_LO) & bus.tready_camera;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, SA_OUT, CAM_LO: begin
        if (w_accept) begin
          w_next = (bus.en == ROUTE_SA) ? SA_OUT : CAM_HI;
        end else if (w_sa_done || w_cam_lo_done) begin
          w_next = IDLE;
        end
      end
      CAM_HI: begin
        if (w_cam_hi_done) begin
          w_next = CAM_LO;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_live     <= 1'b0;
      r_sa_data  <= '0;
      r_sa_last  <= 1'b0;
      r_cam_data <= '0;
      r_cam_last <= 1'b0;
      r_lo_byte  <= '0;
      r_lo_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_accept && (bus.en == ROUTE_SA)) begin
        r_sa_data <= bus.s_tdata;
        r_sa_last <= bus.s_tlast;
      end
      // Each path keeps its own output registers so the idle path holds its last value.
      if (w_accept && (bus.en == ROUTE_CAMERA)) begin
        r_cam_data <= bus.s_tdata[DATA_W-1:BYTE_W];
        r_cam_last <= 1'b0;
        r_lo_byte  <= bus.s_tdata[BYTE_W-1:0];
        r_lo_last  <= bus.s_tlast;
      end else if (w_cam_hi_done) begin
        r_cam_data <= r_lo_byte;
        r_cam_last <= r_lo_last;
      end
    end
  end

  assign bus.s_tready      = w_s_tready;
  assign bus.tvalid_SA     = (r_state == SA_OUT);
  assign bus.tdata_SA      = r_sa_data;
  assign bus.tlast_SA      = r_sa_last;
  assign bus.tvalid_camera = (r_state == CAM_HI) | (r_state == CAM_LO);
  assign bus.tdata_camera  = r_cam_data;
  assign bus.tlast_camera  = r_cam_last;

endmodule

// File: tb/tb_stream_demux.sv
// Directed and random traffic through stream_demux, checked against a queue
// model of the words/bytes each path must deliver.
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;

  stream_demux_if bus_if ();

  stream_demux dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_if)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W:0] sa_q[$];
  logic [BYTE_W:0] cam_q[$];
  logic            prev_sa_v, prev_sa_r, prev_cam_v, prev_cam_r;
  logic [DATA_W:0] prev_sa;
  logic [BYTE_W:0] prev_cam;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard: every accepted word becomes one SA word or two camera bytes.
  always @(negedge aclk) begin
    if (!aresetn) begin
      sa_q.delete();
      cam_q.delete();
      prev_sa_v  = 1'b0;
      prev_sa_r  = 1'b0;
      prev_cam_v = 1'b0;
      prev_cam_r = 1'b0;
      prev_sa    = '0;
      prev_cam   = '0;
    end else begin
      chk("exclusive", 32'(bus_if.tvalid_camera & bus_if.tvalid_SA), 0);
      if (prev_sa_v && !prev_sa_r)
        chk("sa_hold", 32'({bus_if.tvalid_SA, bus_if.tlast_SA, bus_if.tdata_SA}),
            32'({1'b1, prev_sa}));
      if (prev_cam_v && !prev_cam_r)
        chk("cam_hold", 32'({bus_if.tvalid_camera, bus_if.tlast_camera, bus_if.tdata_camera}),
            32'({1'b1, prev_cam}));
      if (bus_if.tvalid_SA && bus_if.tready_SA) begin
        if (sa_q.size() == 0) chk("sa_pending", 32'(sa_q.size()), 1);
        else chk("sa_word", 32'({bus_if.tlast_SA, bus_if.tdata_SA}), 32'(sa_q.pop_front()));
      end
      if (bus_if.tvalid_camera && bus_if.tready_camera) begin
        if (cam_q.size() == 0) chk("cam_pending", 32'(cam_q.size()), 1);
        else chk("cam_byte", 32'({bus_if.tlast_camera, bus_if.tdata_camera}),
                 32'(cam_q.pop_front()));
      end
      if (bus_if.s_tvalid && bus_if.s_tready) begin
        if (bus_if.en) begin
          sa_q.push_back({bus_if.s_tlast, bus_if.s_tdata});
        end else begin
          cam_q.push_back({1'b0, bus_if.s_tdata[15:8]});
          cam_q.push_back({bus_if.s_tlast, bus_if.s_tdata[7:0]});
        end
      end
      prev_sa_v  = bus_if.tvalid_SA;
      prev_sa_r  = bus_if.tready_SA;
      prev_sa    = {bus_if.tlast_SA, bus_if.tdata_SA};
      prev_cam_v = bus_if.tvalid_camera;
      prev_cam_r = bus_if.tready_camera;
      prev_cam   = {bus_if.tlast_camera, bus_if.tdata_camera};
    end
  end

  initial begin
    bus_if.en            = 1'b0;
    bus_if.s_tvalid      = 1'b1;
    bus_if.s_tdata       = 16'h1111;
    bus_if.s_tlast       = 1'b0;
    bus_if.tready_camera = 1'b0;
    bus_if.tready_SA     = 1'b0;

    // Reset held with s_tvalid asserted
    repeat (3) cyc();
    chk("rst_s_tready", 32'(bus_if.s_tready), 0);
    chk("rst_tvalid_cam", 32'(bus_if.tvalid_camera), 0);
    chk("rst_tvalid_sa", 32'(bus_if.tvalid_SA), 0);
    chk("rst_tdata_cam", 32'(bus_if.tdata_camera), 0);
    chk("rst_tdata_sa", 32'(bus_if.tdata_SA), 0);
    chk("rst_tlasts", 32'({bus_if.tlast_camera, bus_if.tlast_SA}), 0);
    bus_if.s_tvalid = 1'b0;
    aresetn = 1'b1;
    #1 chk("rel_rdy_before_edge", 32'(bus_if.s_tready), 0);
    cyc();
    chk("rel_rdy", 32'(bus_if.s_tready), 1);

    // SA burst
    bus_if.en = 1'b1; bus_if.s_tvalid = 1'b1; bus_if.s_tdata = 16'h00ff;
    bus_if.s_tlast = 1'b0; bus_if.tready_SA = 1'b1;
    #1 chk("sa_idle_rdy", 32'(bus_if.s_tready), 1);
    cyc();
    bus_if.s_tdata = 16'he0ff;
    #1 chk("sa_w0_valid", 32'(bus_if.tvalid_SA), 1);
    chk("sa_w0_data", 32'(bus_if.tdata_SA), 'h00ff);
    chk("sa_w0_last", 32'(bus_if.tlast_SA), 0);
    chk("sa_w0_rdy", 32'(bus_if.s_tready), 1);
    cyc();
    bus_if.s_tdata = 16'h1234; bus_if.s_tlast = 1'b1;
    #1 chk("sa_w1_data", 32'(bus_if.tdata_SA), 'he0ff);
    chk("sa_w1_last", 32'(bus_if.tlast_SA), 0);
    chk("sa_w1_rdy", 32'(bus_if.s_tready), 1);
    cyc();
    bus_if.s_tvalid = 1'b0; bus_if.s_tlast = 1'b0;
    #1 chk("sa_w2_data", 32'(bus_if.tdata_SA), 'h1234);
    chk("sa_w2_last", 32'(bus_if.tlast_SA), 1);
    cyc();
    chk("sa_end_valid", 32'(bus_if.tvalid_SA), 0);
    chk("sa_end_hold", 32'(bus_if.tdata_SA), 'h1234);

    // Camera split with back-to-back handoff on the low-byte edge
    bus_if.en = 1'b0; bus_if.s_tvalid = 1'b1; bus_if.s_tdata = 16'he0ff;
    bus_if.s_tlast = 1'b1; bus_if.tready_camera = 1'b1;
    cyc();
    bus_if.s_tdata = 16'h1357; bus_if.s_tlast = 1'b0;
    #1 chk("cam_hi_valid", 32'(bus_if.tvalid_camera), 1);
    chk("cam_hi_data", 32'(bus_if.tdata_camera), 'he0);
    chk("cam_hi_last", 32'(bus_if.tlast_camera), 0);
    chk("cam_hi_rdy", 32'(bus_if.s_tready), 0);
    chk("cam_hi_sa_valid", 32'(bus_if.tvalid_SA), 0);
    cyc();
    #1 chk("cam_lo_data", 32'(bus_if.tdata_camera), 'hff);
    chk("cam_lo_last", 32'(bus_if.tlast_camera), 1);
    chk("cam_lo_rdy", 32'(bus_if.s_tready), 1);
    cyc();
    bus_if.s_tvalid = 1'b0;
    #1 chk("cam_next_hi", 32'(bus_if.tdata_camera), 'h13);
    chk("cam_next_last", 32'(bus_if.tlast_camera), 0);
    cyc();
    chk("cam_next_lo", 32'(bus_if.tdata_camera), 'h57);
    cyc();
    chk("cam_end_valid", 32'(bus_if.tvalid_camera), 0);

    // Camera backpressure in the high byte
    bus_if.tready_camera = 1'b0; bus_if.s_tvalid = 1'b1;
    bus_if.s_tdata = 16'hABCD; bus_if.s_tlast = 1'b0;
    cyc();
    bus_if.s_tvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("bp_valid", 32'(bus_if.tvalid_camera), 1);
      chk("bp_data", 32'(bus_if.tdata_camera), 'hab);
      chk("bp_rdy", 32'(bus_if.s_tready), 0);
      cyc();
    end
    bus_if.tready_camera = 1'b1;
    #1 chk("bp_rel_data", 32'(bus_if.tdata_camera), 'hab);
    cyc();
    chk("bp_lo_data", 32'(bus_if.tdata_camera), 'hcd);
    chk("bp_lo_valid", 32'(bus_if.tvalid_camera), 1);
    cyc();
    chk("bp_end_valid", 32'(bus_if.tvalid_camera), 0);

    // Route bit changed while a camera word is in flight
    bus_if.en = 1'b0; bus_if.s_tvalid = 1'b1; bus_if.s_tdata = 16'h5A5A;
    bus_if.tready_SA = 1'b1;
    cyc();
    bus_if.en = 1'b1; bus_if.s_tdata = 16'h0bb0;
    #1 chk("tog_hi_data", 32'(bus_if.tdata_camera), 'h5a);
    chk("tog_hi_sa_valid", 32'(bus_if.tvalid_SA), 0);
    cyc();
    #1 chk("tog_lo_data", 32'(bus_if.tdata_camera), 'h5a);
    chk("tog_lo_cam_valid", 32'(bus_if.tvalid_camera), 1);
    chk("tog_lo_sa_valid", 32'(bus_if.tvalid_SA), 0);
    chk("tog_lo_rdy", 32'(bus_if.s_tready), 1);
    cyc();
    bus_if.s_tvalid = 1'b0;
    #1 chk("tog_sa_valid", 32'(bus_if.tvalid_SA), 1);
    chk("tog_sa_data", 32'(bus_if.tdata_SA), 'h0bb0);
    chk("tog_sa_cam_valid", 32'(bus_if.tvalid_camera), 0);
    cyc();

    // Asynchronous reset while the low byte is presented
    bus_if.en = 1'b0; bus_if.s_tvalid = 1'b1; bus_if.s_tdata = 16'hC3A5;
    bus_if.s_tlast = 1'b1;
    cyc();
    bus_if.s_tvalid = 1'b0; bus_if.s_tlast = 1'b0;
    cyc();
    #1 chk("ar_lo_data", 32'(bus_if.tdata_camera), 'ha5);
    chk("ar_lo_last", 32'(bus_if.tlast_camera), 1);
    aresetn = 1'b0;
    #1 chk("ar_valid", 32'(bus_if.tvalid_camera), 0);
    chk("ar_data", 32'(bus_if.tdata_camera), 0);
    chk("ar_last", 32'(bus_if.tlast_camera), 0);
    chk("ar_rdy", 32'(bus_if.s_tready), 0);
    cyc();
    cyc();
    aresetn = 1'b1;
    #1 chk("ar_rel_valid", 32'(bus_if.tvalid_camera), 0);
    cyc();
    chk("ar_rel_rdy", 32'(bus_if.s_tready), 1);
    chk("ar_no_stale", 32'(bus_if.tvalid_camera), 0);
    bus_if.s_tvalid = 1'b1; bus_if.s_tdata = 16'h9876;
    cyc();
    bus_if.s_tvalid = 1'b0;
    #1 chk("ar_next_hi", 32'(bus_if.tdata_camera), 'h98);
    cyc();
    chk("ar_next_lo", 32'(bus_if.tdata_camera), 'h76);
    cyc();

    // Random traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      bus_if.s_tvalid      = ($urandom_range(0, 3) != 0);
      bus_if.en            = 1'($urandom_range(0, 1));
      bus_if.s_tdata       = 16'($urandom);
      bus_if.s_tlast       = ($urandom_range(0, 7) == 0);
      bus_if.tready_SA     = ($urandom_range(0, 3) != 0);
      bus_if.tready_camera = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus_if.s_tvalid      = 1'b0;
    bus_if.tready_SA     = 1'b1;
    bus_if.tready_camera = 1'b1;
    repeat (5) cyc();
    chk("drain_sa", 32'(sa_q.size()), 0);
    chk("drain_cam", 32'(cam_q.size()), 0);
    chk("drain_idle", 32'({bus_if.tvalid_SA, bus_if.tvalid_camera}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
